// File: rtl/wishbone_slave_xactor.sv
// wishbone_slave_xactor: Wishbone B4 pipelined slave bridging bus requests to a get FIFO and put responses to ACK beats.
// Optional macro WISHBONE_SLAVE_ERR_EN adds ERR_O / client_response_err with a per-response error flag.
module wishbone_slave_xactor #(
    parameter int DEPTH     = 8,
    parameter int RSP_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] DAT_I,
    output logic        STALL_O,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic [68:0] client_request_get,
    output logic        RDY_client_request_get,
    input  logic        EN_client_request_get,
    input  logic [31:0] client_response_put,
    input  logic        EN_client_response_put,
`ifdef WISHBONE_SLAVE_ERR_EN
    output logic        ERR_O,
    input  logic        client_response_err,
`endif
    output logic        RDY_client_response_put
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int RCW = $clog2(RSP_DEPTH + 1);

    logic [68:0]    req_mem [DEPTH];
    logic [32:0]    rsp_mem [RSP_DEPTH];
    logic [PW-1:0]  req_wp_q, req_wp_d, req_rp_q, req_rp_d;
    logic [CW-1:0]  req_cnt_q, req_cnt_d, out_q, out_d, pend_q, pend_d, disc_q, disc_d;
    logic [RPW-1:0] rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [RCW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic           ack_q, ack_d, err_q, err_d;
    logic [31:0]    dat_q, dat_d;
    logic           accept, abort, req_deq, put, put_keep, rsp_empty, pop, rsp_enq, rsp_deq, beat, err_in;
    logic [32:0]    put_word, head;

`ifdef WISHBONE_SLAVE_ERR_EN
    assign err_in = client_response_err;
    assign ERR_O  = err_q;
`else
    assign err_in = 1'b0;
`endif

    assign STALL_O                 = (out_q == CW'(DEPTH)) | (disc_q != '0);
    assign ACK_O                   = ack_q;
    assign DAT_O                   = dat_q;
    assign client_request_get      = req_mem[req_rp_q];
    assign RDY_client_request_get  = req_cnt_q != '0;
    assign RDY_client_response_put = rsp_cnt_q != RCW'(RSP_DEPTH);

    assign accept    = CYC_I & STB_I & !STALL_O;
    assign abort     = !CYC_I & (out_q != '0);
    assign req_deq   = EN_client_request_get & RDY_client_request_get;
    assign put       = EN_client_response_put & RDY_client_response_put;
    assign put_keep  = put & (disc_q == '0);
    assign rsp_empty = rsp_cnt_q == '0;
    // An empty response FIFO forwards a fresh put straight to the beat register.
    assign pop       = CYC_I & (!rsp_empty | put_keep);
    assign rsp_enq   = put_keep & !(pop & rsp_empty);
    assign rsp_deq   = pop & !rsp_empty;
    assign put_word  = {err_in, client_response_put};
    assign head      = rsp_empty ? put_word : rsp_mem[rsp_rp_q];
    assign beat      = ack_q | err_q;

    always_comb begin
        req_wp_d  = abort ? '0 : req_wp_q + PW'(accept);
        req_rp_d  = abort ? '0 : req_rp_q + PW'(req_deq);
        req_cnt_d = abort ? '0 : req_cnt_q + CW'(accept) - CW'(req_deq);
        rsp_wp_d  = abort ? '0 : rsp_wp_q + RPW'(rsp_enq);
        rsp_rp_d  = abort ? '0 : rsp_rp_q + RPW'(rsp_deq);
        rsp_cnt_d = abort ? '0 : rsp_cnt_q + RCW'(rsp_enq) - RCW'(rsp_deq);
        out_d     = abort ? '0 : out_q + CW'(accept) - CW'(beat);
        pend_d    = abort ? '0 : pend_q + CW'(req_deq) - CW'(put_keep);
        // Requests already handed to the client must have their late responses swallowed.
        disc_d    = abort ? pend_q + CW'(req_deq) - CW'(put) : disc_q - CW'(put & (disc_q != '0));
        ack_d     = pop & !head[32];
        err_d     = pop & head[32];
        dat_d     = pop ? head[31:0] : dat_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_wp_q  <= '0;
            req_rp_q  <= '0;
            req_cnt_q <= '0;
            rsp_wp_q  <= '0;
            rsp_rp_q  <= '0;
            rsp_cnt_q <= '0;
            out_q     <= '0;
            pend_q    <= '0;
            disc_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            req_wp_q  <= req_wp_d;
            req_rp_q  <= req_rp_d;
            req_cnt_q <= req_cnt_d;
            rsp_wp_q  <= rsp_wp_d;
            rsp_rp_q  <= rsp_rp_d;
            rsp_cnt_q <= rsp_cnt_d;
            out_q     <= out_d;
            pend_q    <= pend_d;
            disc_q    <= disc_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) req_mem[req_wp_q] <= {WE_I, SEL_I, ADR_I, DAT_I};
        if (rsp_enq) rsp_mem[rsp_wp_q] <= put_word;
    end
endmodule

// File: tb/tb_wishbone_slave_xactor.sv
// tb_wishbone_slave_xactor: scoreboard bench for the Wishbone slave transactor.
module tb_wishbone_slave_xactor;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
    logic [31:0] ADR_I = '0, DAT_I = '0, client_response_put = '0;
    logic [3:0]  SEL_I = '0;
    logic        EN_client_request_get = 1'b0, EN_client_response_put = 1'b0;
    logic        STALL_O, ACK_O, RDY_client_request_get, RDY_client_response_put;
    logic [31:0] DAT_O;
    logic [68:0] client_request_get;
`ifdef WISHBONE_SLAVE_ERR_EN
    logic        ERR_O;
    logic        client_response_err = 1'b0;
`endif

    int checks = 0, failures = 0, acks_seen = 0;
    logic [31:0] exp_rsp[$];
    logic [68:0] exp_req[$];
    logic [31:0] mon_rsp;
    logic [68:0] mon_req;

    wishbone_slave_xactor dut (
        .CLK(CLK), .RST(RST), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ADR_I(ADR_I), .SEL_I(SEL_I), .DAT_I(DAT_I), .STALL_O(STALL_O),
        .ACK_O(ACK_O), .DAT_O(DAT_O), .client_request_get(client_request_get),
        .RDY_client_request_get(RDY_client_request_get),
        .EN_client_request_get(EN_client_request_get),
        .client_response_put(client_response_put),
        .EN_client_response_put(EN_client_response_put),
`ifdef WISHBONE_SLAVE_ERR_EN
        .ERR_O(ERR_O), .client_response_err(client_response_err),
`endif
        .RDY_client_response_put(RDY_client_response_put)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RST && ACK_O) begin
            acks_seen++;
            checks++;
            if (exp_rsp.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: DAT_O=%h with no response pending", DAT_O);
            end else begin
                mon_rsp = exp_rsp.pop_front();
                if (DAT_O !== mon_rsp) begin
                    failures++;
                    $display("FAIL ack_data: DAT_O=%h expected %h", DAT_O, mon_rsp);
                end
            end
        end
        if (!RST && EN_client_request_get && RDY_client_request_get) begin
            checks++;
            if (exp_req.size() == 0) begin
                failures++;
                $display("FAIL unexpected_req: get=%h with no request pending", client_request_get);
            end else begin
                mon_req = exp_req.pop_front();
                if (client_request_get !== mon_req) begin
                    failures++;
                    $display("FAIL req_data: get=%h expected %h", client_request_get, mon_req);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_get();
        int n = 0;
        while (RDY_client_request_get !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++;
            failures++;
            $display("FAIL wait_get: RDY_client_request_get=%b expected 1 within 50 cycles", RDY_client_request_get);
        end
    endtask

    task automatic send_reads(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            STB_I = 1'b1; WE_I = 1'b0; ADR_I = base + 32'(4 * i); SEL_I = 4'hF; DAT_I = '0;
            checks++;
            if (STALL_O !== 1'b0) begin failures++; $display("FAIL read_stall: STALL_O=%b expected 0", STALL_O); end
            exp_req.push_back({1'b0, 4'hF, ADR_I, 32'h0});
            step();
        end
        STB_I = 1'b0;
    endtask

    task automatic drain(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wait_get();
            EN_client_request_get = 1'b1;
            step();
            EN_client_request_get = 1'b0;
            client_response_put = base + 32'(i);
            EN_client_response_put = 1'b1;
            exp_rsp.push_back(client_response_put);
            step();
            EN_client_response_put = 1'b0;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        checks++; if (STALL_O !== 1'b0) begin failures++; $display("FAIL reset_stall: STALL_O=%b expected 0", STALL_O); end
        checks++; if (ACK_O !== 1'b0) begin failures++; $display("FAIL reset_ack: ACK_O=%b expected 0", ACK_O); end
        step();
        RST = 1'b0;
        step();
        checks++; if (DAT_O !== 32'h0) begin failures++; $display("FAIL reset_dat: DAT_O=%h expected 0", DAT_O); end
        checks++; if (RDY_client_request_get !== 1'b0) begin failures++; $display("FAIL reset_rdy_get: %b expected 0", RDY_client_request_get); end
        checks++; if (RDY_client_response_put !== 1'b1) begin failures++; $display("FAIL reset_rdy_put: %b expected 1", RDY_client_response_put); end
    endtask

    task automatic test_single_read();
        CYC_I = 1'b1;
        send_reads(1, 32'h100);
        checks++; if (RDY_client_request_get !== 1'b1) begin failures++; $display("FAIL single_rdy_get: %b expected 1", RDY_client_request_get); end
        checks++; if (client_request_get[68:32] !== {1'b0, 4'hF, 32'h100}) begin failures++; $display("FAIL single_get: %h expected 0f00000100", client_request_get[68:32]); end
        EN_client_request_get = 1'b1;
        step();
        EN_client_request_get = 1'b0;
        checks++; if (RDY_client_request_get !== 1'b0) begin failures++; $display("FAIL single_rdy_after_deq: %b expected 0", RDY_client_request_get); end
        client_response_put = 32'hDEADBEEF;
        EN_client_response_put = 1'b1;
        exp_rsp.push_back(32'hDEADBEEF);
        step();
        EN_client_response_put = 1'b0;
        checks++; if (ACK_O !== 1'b1 || DAT_O !== 32'hDEADBEEF) begin failures++; $display("FAIL single_ack: ACK_O=%b DAT_O=%h expected 1 deadbeef", ACK_O, DAT_O); end
        step();
        checks++; if (ACK_O !== 1'b0 || DAT_O !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold: ACK_O=%b DAT_O=%h expected 0 deadbeef", ACK_O, DAT_O); end
        checks++; if (dut.out_q !== 4'd0) begin failures++; $display("FAIL single_outstanding: %0d expected 0", dut.out_q); end
    endtask

    task automatic test_back_to_back();
        CYC_I = 1'b1;
        for (int i = 0; i < 8; i++) begin
            STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'(i); SEL_I = 4'hF; DAT_I = 32'hA000_0000 | 32'(i);
            checks++;
            if (STALL_O !== 1'b0) begin failures++; $display("FAIL b2b_stall_%0d: STALL_O=%b expected 0", i, STALL_O); end
            exp_req.push_back({1'b1, 4'hF, ADR_I, DAT_I});
            step();
        end
        ADR_I = 32'h8; DAT_I = 32'hA000_0008;
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL b2b_full: STALL_O=%b expected 1", STALL_O); end
        step();
        step();
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL b2b_held: STALL_O=%b expected 1", STALL_O); end
        EN_client_request_get = 1'b1;
        step();
        EN_client_request_get = 1'b0;
        client_response_put = 32'h1000;
        EN_client_response_put = 1'b1;
        exp_rsp.push_back(32'h1000);
        step();
        EN_client_response_put = 1'b0;
        checks++; if (ACK_O !== 1'b1 || STALL_O !== 1'b1) begin failures++; $display("FAIL b2b_ack: ACK_O=%b STALL_O=%b expected 1 1", ACK_O, STALL_O); end
        step();
        checks++; if (STALL_O !== 1'b0) begin failures++; $display("FAIL b2b_release: STALL_O=%b expected 0", STALL_O); end
        exp_req.push_back({1'b1, 4'hF, 32'h8, 32'hA000_0008});
        step();
        STB_I = 1'b0;
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL b2b_refull: STALL_O=%b expected 1", STALL_O); end
        drain(8, 32'h2000);
        checks++; if (dut.out_q !== 4'd0 || exp_rsp.size() != 0 || exp_req.size() != 0) begin
            failures++; $display("FAIL b2b_drain: outstanding=%0d rsp_left=%0d req_left=%0d expected 0 0 0", dut.out_q, exp_rsp.size(), exp_req.size());
        end
    endtask

    task automatic test_pipelined();
        int base;
        CYC_I = 1'b1;
        send_reads(4, 32'h200);
        EN_client_request_get = 1'b1;
        repeat (4) step();
        EN_client_request_get = 1'b0;
        checks++; if (exp_req.size() != 0) begin failures++; $display("FAIL pipe_deq: %0d requests left expected 0", exp_req.size()); end
        base = acks_seen;
        for (int i = 0; i < 4; i++) begin
            client_response_put = 32'hC0DE_0000 + 32'(i);
            EN_client_response_put = 1'b1;
            checks++; if (RDY_client_response_put !== 1'b1) begin failures++; $display("FAIL pipe_rdy_put_%0d: %b expected 1", i, RDY_client_response_put); end
            exp_rsp.push_back(client_response_put);
            step();
            checks++; if (ACK_O !== 1'b1) begin failures++; $display("FAIL pipe_ack_%0d: ACK_O=%b expected 1", i, ACK_O); end
        end
        EN_client_response_put = 1'b0;
        step();
        checks++; if (ACK_O !== 1'b0) begin failures++; $display("FAIL pipe_no_extra_ack: ACK_O=%b expected 0", ACK_O); end
        checks++; if (acks_seen - base != 4) begin failures++; $display("FAIL pipe_ack_count: %0d expected 4", acks_seen - base); end
        checks++; if (dut.out_q !== 4'd0) begin failures++; $display("FAIL pipe_outstanding: %0d expected 0", dut.out_q); end
    endtask

    task automatic test_abort();
        CYC_I = 1'b1;
        send_reads(3, 32'h300);
        EN_client_request_get = 1'b1;
        step();
        step();
        EN_client_request_get = 1'b0;
        CYC_I = 1'b0;
        step();
        exp_req.delete();
        checks++; if (RDY_client_request_get !== 1'b0) begin failures++; $display("FAIL abort_flush: RDY_get=%b expected 0", RDY_client_request_get); end
        checks++; if (dut.disc_q !== 4'd2) begin failures++; $display("FAIL abort_discard: %0d expected 2", dut.disc_q); end
        checks++; if (STALL_O !== 1'b1 || ACK_O !== 1'b0) begin failures++; $display("FAIL abort_stall: STALL_O=%b ACK_O=%b expected 1 0", STALL_O, ACK_O); end
        checks++; if (dut.out_q !== 4'd0) begin failures++; $display("FAIL abort_outstanding: %0d expected 0", dut.out_q); end
        CYC_I = 1'b1;
        client_response_put = 32'hBAD1;
        EN_client_response_put = 1'b1;
        step();
        checks++; if (ACK_O !== 1'b0 || STALL_O !== 1'b1) begin failures++; $display("FAIL abort_drop1: ACK_O=%b STALL_O=%b expected 0 1", ACK_O, STALL_O); end
        client_response_put = 32'hBAD2;
        step();
        EN_client_response_put = 1'b0;
        checks++; if (ACK_O !== 1'b0 || STALL_O !== 1'b0) begin failures++; $display("FAIL abort_drop2: ACK_O=%b STALL_O=%b expected 0 0", ACK_O, STALL_O); end
        step();
        checks++; if (ACK_O !== 1'b0) begin failures++; $display("FAIL abort_quiet: ACK_O=%b expected 0", ACK_O); end
    endtask

    task automatic test_reset_mid();
        CYC_I = 1'b1;
        send_reads(5, 32'h400);
        EN_client_request_get = 1'b1;
        step();
        EN_client_request_get = 1'b0;
        client_response_put = 32'h5555_AAAA;
        EN_client_response_put = 1'b1;
        exp_rsp.push_back(32'h5555_AAAA);
        step();
        EN_client_response_put = 1'b0;
        checks++; if (ACK_O !== 1'b1 || dut.out_q !== 4'd5) begin failures++; $display("FAIL rst_setup: ACK_O=%b outstanding=%0d expected 1 5", ACK_O, dut.out_q); end
        RST = 1'b1;
        #1;
        exp_rsp.delete();
        exp_req.delete();
        checks++; if (STALL_O !== 1'b0 || ACK_O !== 1'b0 || DAT_O !== 32'h0) begin failures++; $display("FAIL rst_outputs: STALL_O=%b ACK_O=%b DAT_O=%h expected 0 0 0", STALL_O, ACK_O, DAT_O); end
        checks++; if (RDY_client_request_get !== 1'b0 || RDY_client_response_put !== 1'b1) begin failures++; $display("FAIL rst_rdy: get=%b put=%b expected 0 1", RDY_client_request_get, RDY_client_response_put); end
        checks++; if (dut.out_q !== 4'd0 || dut.disc_q !== 4'd0) begin failures++; $display("FAIL rst_counters: outstanding=%0d discard=%0d expected 0 0", dut.out_q, dut.disc_q); end
        CYC_I = 1'b0;
        step();
        RST = 1'b0;
        step();
    endtask

`ifdef WISHBONE_SLAVE_ERR_EN
    task automatic test_err();
        CYC_I = 1'b1;
        send_reads(1, 32'h500);
        EN_client_request_get = 1'b1;
        step();
        EN_client_request_get = 1'b0;
        client_response_put = 32'hE;
        client_response_err = 1'b1;
        EN_client_response_put = 1'b1;
        step();
        EN_client_response_put = 1'b0;
        client_response_err = 1'b0;
        checks++; if (ERR_O !== 1'b1 || ACK_O !== 1'b0) begin failures++; $display("FAIL err_beat: ERR_O=%b ACK_O=%b expected 1 0", ERR_O, ACK_O); end
        step();
        checks++; if (ERR_O !== 1'b0 || dut.out_q !== 4'd0) begin failures++; $display("FAIL err_done: ERR_O=%b outstanding=%0d expected 0 0", ERR_O, dut.out_q); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_pipelined();
        test_abort();
        test_reset_mid();
`ifdef WISHBONE_SLAVE_ERR_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
